// File: rtl/l293d_pkg.sv
// Shared types and pin mapping for the dual-channel L293D H-bridge controller.
package l293d_pkg;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    BRAKE = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } chan_state_t;

  // One channel's driver pins: first/second direction pin and enable.
  typedef struct packed {
    logic in_a;
    logic in_b;
    logic en;
  } pins_t;

  // Map a direction and the current PWM level to driver pins.
  function automatic pins_t dir_to_pins(input dir_t dir, input logic pwm);
    pins_t p;
    p = '0;
    case (dir)
      FWD: begin
        p.in_a = 1'b1;
        p.en   = pwm;
      end
      REV: begin
        p.in_b = 1'b1;
        p.en   = pwm;
      end
      BRAKE: begin
        p.in_a = 1'b1;
        p.in_b = 1'b1;
        p.en   = 1'b1;
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/l293d_ctrl_chan.sv
// One H-bridge channel: command handshake, one-deep pending register,
// dead-time sequencing on direction reversal and optional soft-start
// (enabled by defining L293D_CTRL_SOFTSTART_EN).
module l293d_ctrl_chan
  import l293d_pkg::*;
#(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_i,
  input  logic              boundary_i,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_dir_i,
  input  logic [PWM_W-1:0]  cmd_duty_i,
  output logic              cmd_ready_o,
  output chan_state_t       state_o,
  output dir_t              dir_o,
  output logic [PWM_W-1:0]  duty_o,
  output logic              busy_o
);

  localparam int unsigned DW = $clog2(DEAD_CYC + 1);

  chan_state_t      state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pend_q, pend_d;
  dir_t             pend_dir_q, pend_dir_d;
  logic [PWM_W-1:0] pend_duty_q, pend_duty_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             busy_q, busy_d;
`ifdef L293D_CTRL_SOFTSTART_EN
  logic [PWM_W-1:0] target_q, target_d;
`endif

  logic accept;
  logic apply;
  dir_t cmd_dir;

  assign cmd_ready_o = !pend_q && !stop_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign cmd_dir     = dir_t'(cmd_dir_i);

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= COAST;
      duty_q      <= '0;
      pend_q      <= 1'b0;
      pend_dir_q  <= COAST;
      pend_duty_q <= '0;
      dead_q      <= '0;
      busy_q      <= 1'b0;
`ifdef L293D_CTRL_SOFTSTART_EN
      target_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      pend_dir_q  <= pend_dir_d;
      pend_duty_q <= pend_duty_d;
      dead_q      <= dead_d;
      busy_q      <= busy_d;
`ifdef L293D_CTRL_SOFTSTART_EN
      target_q    <= target_d;
`endif
    end
  end

  // Next state: stop override, pending apply, dead-time countdown, accept.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    duty_d      = duty_q;
    pend_d      = pend_q;
    pend_dir_d  = pend_dir_q;
    pend_duty_d = pend_duty_q;
    dead_d      = dead_q;
    apply       = 1'b0;
`ifdef L293D_CTRL_SOFTSTART_EN
    target_d    = target_q;
`endif

    if (stop_i) begin
      state_d     = IDLE;
      dir_d       = COAST;
      duty_d      = '0;
      pend_d      = 1'b0;
      pend_dir_d  = COAST;
      pend_duty_d = '0;
      dead_d      = '0;
`ifdef L293D_CTRL_SOFTSTART_EN
      target_d    = '0;
`endif
    end else begin
      // Dead-time exit applies immediately; otherwise wait for the boundary.
      if (state_q == DEAD) begin
        dead_d = dead_q - DW'(1);
        apply  = (dead_q <= DW'(1));
      end else begin
        apply  = pend_q && boundary_i;
      end

      if (apply) begin
        dir_d   = pend_dir_q;
        state_d = (pend_dir_q == COAST) ? IDLE : RUN;
        pend_d  = 1'b0;
`ifdef L293D_CTRL_SOFTSTART_EN
        target_d = pend_duty_q;
        if (state_q != RUN) begin
          duty_d = '0;
        end else if (pend_duty_q < duty_q) begin
          duty_d = pend_duty_q;
        end else if (duty_q < pend_duty_q) begin
          duty_d = duty_q + PWM_W'(1);
        end
`else
        duty_d = pend_duty_q;
`endif
      end
`ifdef L293D_CTRL_SOFTSTART_EN
      else if ((state_q == RUN) && boundary_i && (duty_q < target_q)) begin
        duty_d = duty_q + PWM_W'(1);
      end
`endif

      // A reversal on a running channel starts dead-time right away.
      if (accept) begin
        pend_d      = 1'b1;
        pend_dir_d  = cmd_dir;
        pend_duty_d = cmd_duty_i;
        if ((state_q == RUN) && (cmd_dir != dir_q)) begin
          state_d = DEAD;
          dead_d  = DW'(DEAD_CYC);
        end
      end
    end

    busy_d = (state_d == DEAD) || pend_d;
`ifdef L293D_CTRL_SOFTSTART_EN
    busy_d = busy_d || ((state_d == RUN) && (duty_d != target_d));
`endif
  end

  assign state_o = state_q;
  assign dir_o   = dir_q;
  assign duty_o  = duty_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/l293d_ctrl.sv
// Dual-channel L293D controller top: shared PWM counter, two channel FSMs
// and registered driver pins. Soft-start is built in when the macro
// L293D_CTRL_SOFTSTART_EN is defined.
module l293d_ctrl
  import l293d_pkg::*;
#(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             cmd_valid_a,
  input  logic             cmd_valid_b,
  output logic             cmd_ready_a,
  output logic             cmd_ready_b,
  input  logic [1:0]       cmd_dir_a,
  input  logic [1:0]       cmd_dir_b,
  input  logic [PWM_W-1:0] cmd_duty_a,
  input  logic [PWM_W-1:0] cmd_duty_b,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             in4,
  output logic             enA,
  output logic             enB,
  output logic             busy_a,
  output logic             busy_b
);

  localparam int unsigned PERIOD = (1 << PWM_W) - 1;

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             boundary;

  chan_state_t      state_a, state_b;
  dir_t             dir_a, dir_b;
  logic [PWM_W-1:0] duty_a, duty_b;

  pins_t            pins_a_q, pins_a_d;
  pins_t            pins_b_q, pins_b_d;

  assign boundary = (cnt_q == PWM_W'(PERIOD - 1));

  // Shared PWM counter, wraps after PERIOD cycles.
  always_comb begin
    cnt_d = boundary ? '0 : cnt_q + PWM_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  l293d_ctrl_chan #(
    .PWM_W    (PWM_W),
    .DEAD_CYC (DEAD_CYC)
  ) u_chan_a (
    .clk         (clk),
    .rst         (rst),
    .stop_i      (stop),
    .boundary_i  (boundary),
    .cmd_valid_i (cmd_valid_a),
    .cmd_dir_i   (cmd_dir_a),
    .cmd_duty_i  (cmd_duty_a),
    .cmd_ready_o (cmd_ready_a),
    .state_o     (state_a),
    .dir_o       (dir_a),
    .duty_o      (duty_a),
    .busy_o      (busy_a)
  );

  l293d_ctrl_chan #(
    .PWM_W    (PWM_W),
    .DEAD_CYC (DEAD_CYC)
  ) u_chan_b (
    .clk         (clk),
    .rst         (rst),
    .stop_i      (stop),
    .boundary_i  (boundary),
    .cmd_valid_i (cmd_valid_b),
    .cmd_dir_i   (cmd_dir_b),
    .cmd_duty_i  (cmd_duty_b),
    .cmd_ready_o (cmd_ready_b),
    .state_o     (state_b),
    .dir_o       (dir_b),
    .duty_o      (duty_b),
    .busy_o      (busy_b)
  );

  // Pin decode; anything other than RUN drives the coast pattern.
  always_comb begin
    pins_a_d = dir_to_pins((state_a == RUN) ? dir_a : COAST, cnt_q < duty_a);
    pins_b_d = dir_to_pins((state_b == RUN) ? dir_b : COAST, cnt_q < duty_b);
  end

  // Registered driver pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pins_a_q <= '0;
      pins_b_q <= '0;
    end else begin
      pins_a_q <= pins_a_d;
      pins_b_q <= pins_b_d;
    end
  end

  assign in1 = pins_a_q.in_a;
  assign in2 = pins_a_q.in_b;
  assign enA = pins_a_q.en;
  assign in3 = pins_b_q.in_a;
  assign in4 = pins_b_q.in_b;
  assign enB = pins_b_q.en;

endmodule

// File: tb/tb_l293d_ctrl.sv
// Self-checking bench for l293d_ctrl (default build, soft-start disabled).
module tb_l293d_ctrl;

  localparam int PERIOD   = 255;
  localparam int DEAD_CYC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       v  [2];
  logic [1:0] dr [2];
  logic [7:0] du [2];
  logic       cmd_ready_a, cmd_ready_b;
  logic       in1, in2, in3, in4, enA, enB, busy_a, busy_b;

  always #5 clk = ~clk;

  l293d_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stop        (stop),
    .cmd_valid_a (v[0]),
    .cmd_valid_b (v[1]),
    .cmd_ready_a (cmd_ready_a),
    .cmd_ready_b (cmd_ready_b),
    .cmd_dir_a   (dr[0]),
    .cmd_dir_b   (dr[1]),
    .cmd_duty_a  (du[0]),
    .cmd_duty_b  (du[1]),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .in4         (in4),
    .enA         (enA),
    .enB         (enB),
    .busy_a      (busy_a),
    .busy_b      (busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: applied direction/duty, pending command, and remaining
  // dead-time cycles per channel (0 means not in dead-time).
  int m_cnt;
  int m_dir   [2];
  int m_duty  [2];
  int m_pend  [2];
  int m_pdir  [2];
  int m_pduty [2];
  int m_dead  [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_dir[c] = 0; m_duty[c] = 0; m_pend[c] = 0;
      m_pdir[c] = 0; m_pduty[c] = 0; m_dead[c] = 0;
    end
  endtask

  function automatic logic [2:0] exp_pins(input int c);
    logic pwm;
    pwm = (m_cnt < m_duty[c]);
    if (m_dead[c] > 0) return 3'b000;
    case (m_dir[c])
      1:       return {2'b10, pwm};
      2:       return {2'b01, pwm};
      3:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_apply(input int c);
    m_dir[c]  = m_pdir[c];
    m_duty[c] = m_pduty[c];
    m_pend[c] = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_edge();
    bit bnd;
    bit acc;
    bnd = (m_cnt == PERIOD - 1);
    if (stop) begin
      for (int c = 0; c < 2; c++) begin
        m_dir[c] = 0; m_duty[c] = 0; m_pend[c] = 0; m_dead[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        acc = v[c] && (m_pend[c] == 0);
        if (m_dead[c] > 0) begin
          m_dead[c]--;
          if (m_dead[c] == 0) model_apply(c);
        end else if (m_pend[c] != 0 && bnd) begin
          model_apply(c);
        end
        if (acc) begin
          m_pend[c]  = 1;
          m_pdir[c]  = int'(dr[c]);
          m_pduty[c] = int'(du[c]);
          if (m_dir[c] != 0 && int'(dr[c]) != m_dir[c]) m_dead[c] = DEAD_CYC;
        end
      end
    end
    m_cnt = bnd ? 0 : m_cnt + 1;
  endtask

  // One clock: check ready before the edge, pins and busy after it.
  task automatic tick();
    logic [5:0] ep;
    logic [1:0] er;
    logic [1:0] eb;
    #1;
    er[0] = (m_pend[0] == 0) && !stop;
    er[1] = (m_pend[1] == 0) && !stop;
    check("ready", {6'b0, cmd_ready_b, cmd_ready_a}, {6'b0, er});
    ep = {exp_pins(0), exp_pins(1)};
    @(posedge clk);
    model_edge();
    @(negedge clk);
    eb[0] = (m_dead[0] > 0) || (m_pend[0] != 0);
    eb[1] = (m_dead[1] > 0) || (m_pend[1] != 0);
    check("pins", {2'b0, in1, in2, enA, in3, in4, enB}, {2'b0, ep});
    check("busy", {6'b0, busy_b, busy_a}, {6'b0, eb});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Hold valid until the command is taken; returns cycles spent waiting.
  task automatic send(input int c, input int dir, input int duty, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    v[c] = 1'b1; dr[c] = 2'(dir); du[c] = 8'(duty);
    for (int k = 0; k < 1000 && !acc; k++) begin
      acc = (m_pend[c] == 0) && !stop;
      tick();
      if (!acc) waited++;
    end
    v[c] = 1'b0;
    check("send_acc", {7'b0, acc}, 8'd1);
  endtask

  // Count enable-high cycles over one full period.
  task automatic count_en(input int c, output int hi);
    hi = 0;
    repeat (PERIOD) begin
      tick();
      hi += (c == 0) ? int'(enA) : int'(enB);
    end
  endtask

  // Length of the 0/0 run on a channel's direction pins after a reversal.
  task automatic measure_dead(input int c, output int n);
    logic [1:0] pp;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      pp = (c == 0) ? {in1, in2} : {in3, in4};
      if (pp == 2'b00) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int hi;
    int nd;
    rst = 1'b1; stop = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v[c] = 1'b0; dr[c] = 2'd0; du[c] = 8'd0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pins", {2'b0, in1, in2, enA, in3, in4, enB}, 8'd0);
    check("rst_busy", {6'b0, busy_b, busy_a}, 8'd0);
    rst = 1'b0;
    tick();

    // FWD 128 on A
    send(0, 1, 128, w);
    run(300);
    count_en(0, hi);
    check("dutyA128", 8'(hi), 8'd128);
    check("fwdA_dir", {4'b0, in1, in2, in3, in4}, 8'b0000_1000);

    // Full-on then full-off
    send(0, 1, 255, w);
    run(300);
    count_en(0, hi);
    check("dutyA255", 8'(hi), 8'd255);
    send(0, 1, 0, w);
    run(300);
    count_en(0, hi);
    check("dutyA0", 8'(hi), 8'd0);

    // Reversal FWD -> REV 64 with dead-time
    send(0, 1, 200, w);
    run(300);
    send(0, 2, 64, w);
    measure_dead(0, nd);
    check("deadA_len", 8'(nd), 8'(DEAD_CYC));
    check("deadA_dir", {6'b0, in1, in2}, 8'b01);
    run(300);
    count_en(0, hi);
    check("dutyA64", 8'(hi), 8'd64);

    // Second command while the first is pending
    send(0, 2, 100, w);
    send(0, 2, 30, w);
    check("held_off", {7'b0, w > 0}, 8'd1);
    run(600);
    count_en(0, hi);
    check("dutyA30", 8'(hi), 8'd30);

    // BRAKE while running REV
    send(0, 3, 0, w);
    measure_dead(0, nd);
    check("deadB_len", 8'(nd), 8'(DEAD_CYC));
    run(20);
    count_en(0, hi);
    check("brakeA_en", 8'(hi), 8'd255);
    check("brakeA_dir", {6'b0, in1, in2}, 8'b11);

    // stop mid-DEAD on A while B runs
    send(1, 2, 100, w);
    run(300);
    send(0, 1, 50, w);
    run(5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("stop_pins", {2'b0, in1, in2, enA, in3, in4, enB}, 8'd0);
    check("stop_busy", {6'b0, busy_b, busy_a}, 8'd0);
    run(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stop = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 2; c++) begin
        v[c]  = ($urandom_range(0, 5) == 0);
        dr[c] = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       du[c] = 8'd0;
          1:       du[c] = 8'hFF;
          default: du[c] = 8'($urandom_range(0, 255));
        endcase
      end
      tick();
    end
    stop = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    run(20);

    // Asynchronous reset in the middle of dead-time
    send(0, 1, 200, w);
    run(300);
    send(0, 2, 64, w);
    run(5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pins", {2'b0, in1, in2, enA, in3, in4, enB}, 8'd0);
    check("arst_busy", {6'b0, busy_b, busy_a}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(20);
    send(1, 1, 77, w);
    run(300);
    count_en(1, hi);
    check("dutyB77", 8'(hi), 8'd77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
